imem_fetch_unit: RTL and testbench

IMEM_FETCH_UNIT -- requirements
Module: imem_fetch_unit

---
 rtl/imem_fetch_unit.sv | 93 +++++++++
 tb/tb_imem_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_unit.sv
// Byte-addressed instruction memory with a one-deep registered fetch response.
// Define IMEM_PROG_PORT_EN to enable the byte-wide program port.
module imem_fetch_unit #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_BYTES = 4096,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] address,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] instruction,
    output logic              resp_err,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data
);

    localparam int NB  = DATA_W / 8;
    localparam int LGN = $clog2(NB);
    localparam int MW  = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH_BYTES - NB);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state, state_n;

    logic [7:0]        mem [DEPTH_BYTES];
    logic              accept;
    logic              fault;
    logic [MW-1:0]     base;
    logic [DATA_W-1:0] word;

    assign resp_valid = (state == FULL);
    assign req_ready  = !resp_valid || resp_ready;
    assign accept     = req_valid && req_ready;

    // Out-of-range never wraps: compare the full address, not the index.
    assign fault = (address[LGN-1:0] != '0) || (address > LAST);
    assign base  = address[MW-1:0];

    always_comb begin
        word = '0;
        for (int b = 0; b < NB; b++) begin
            word[8*b +: 8] = mem[base + MW'(b)];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            EMPTY: if (accept) state_n = FULL;
            FULL:  if (resp_ready && !accept) state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instruction <= '0;
            resp_err    <= 1'b0;
        end else if (accept) begin
            instruction <= fault ? '0 : word;
            resp_err    <= fault;
        end
    end

`ifdef IMEM_PROG_PORT_EN
    // Same-edge read above sees the old byte: read-before-write.
    always_ff @(posedge clk) begin
        if (rst && prog_we && ({1'b0, prog_addr} < (ADDR_W+1)'(DEPTH_BYTES))) begin
            mem[prog_addr[MW-1:0]] <= prog_data;
        end
    end
`else
    logic unused_prog;
    assign unused_prog = ^{prog_we, prog_addr, prog_data};
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: byte-array reference model,
// directed fetch cases plus randomized handshake/program traffic.
module tb_imem_fetch_unit;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] address = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] instruction;
    logic        resp_err;
    logic        prog_we = 1'b0;
    logic [31:0] prog_addr = '0;
    logic [7:0]  prog_data = '0;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] ins;
        logic        err;
    } rsp_t;

    logic [7:0] model_mem [DEPTH];
    rsp_t       expq [$];
    bit         m_full = 1'b0;

    always #5 clk = ~clk;

    imem_fetch_unit #(
        .DATA_W(32),
        .DEPTH_BYTES(DEPTH),
        .ADDR_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .address(address),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .instruction(instruction),
        .resp_err(resp_err),
        .prog_we(prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic rsp_t predict(input logic [31:0] a);
        rsp_t r;
        if ((a % 4) != 0 || a > DEPTH - 4) begin
            r.ins = '0;
            r.err = 1'b1;
        end else begin
            r.ins = {model_mem[a+3], model_mem[a+2],
                     model_mem[a+1], model_mem[a]};
            r.err = 1'b0;
        end
        return r;
    endfunction

    // Reference model: handshake as a one-slot buffer, memory as a byte array.
    always @(negedge clk) begin
        bit m_ready;
        if (!rst) begin
            m_full = 1'b0;
            expq.delete();
        end else begin
            m_ready = !m_full || resp_ready;
            chk("req_ready", req_ready, m_ready);
            chk("resp_valid", resp_valid, m_full);
            if (req_valid && m_ready) begin
                expq.push_back(predict(address));
                m_full = 1'b1;
            end else if (resp_ready) begin
                m_full = 1'b0;
            end
`ifdef IMEM_PROG_PORT_EN
            if (prog_we && prog_addr < DEPTH) model_mem[prog_addr] = prog_data;
`endif
        end
    end

    // Monitor: every presented response must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && resp_valid) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got valid ins %h, required none",
                         instruction);
            end else begin
                chk("instruction", instruction, expq[0].ins);
                chk("resp_err", resp_err, expq[0].err);
                if (resp_ready) void'(expq.pop_front());
            end
        end
    end

    task automatic cyc(input logic rv, input logic [31:0] a, input logic rr,
                       input logic pw, input logic [31:0] pa,
                       input logic [7:0] pd);
        req_valid  = rv;
        address    = a;
        resp_ready = rr;
        prog_we    = pw;
        prog_addr  = pa;
        prog_data  = pd;
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input int a, input logic [7:0] v);
`ifdef IMEM_PROG_PORT_EN
        cyc(1'b0, '0, 1'b1, 1'b1, 32'(a), v);
`else
        dut.mem[a] = v;
        model_mem[a] = v;
`endif
    endtask

    task automatic fetch(input logic [31:0] a, input logic rr);
        cyc(1'b1, a, rr, 1'b0, '0, '0);
    endtask

    task automatic idle(input logic rr);
        cyc(1'b0, '0, rr, 1'b0, '0, '0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] pa;
        int k;

        #1;
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_instruction", instruction, '0);
        chk("rst_resp_err", resp_err, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        load_byte(0, 8'h28);
        load_byte(1, 8'h00);
        load_byte(2, 8'h01);
        load_byte(3, 8'h20);
        for (int i = 4; i < 256; i++) load_byte(i, (i == 16) ? 8'h55 : 8'($urandom));
        for (int i = 16'hF00; i < DEPTH; i++) load_byte(i, 8'($urandom));

        fetch(32'h0, 1'b1);
        idle(1'b1);

        fetch(32'h2, 1'b1);
        fetch(32'hFFC, 1'b1);
        fetch(32'h1000, 1'b1);
        fetch(32'hFFFF_FFFC, 1'b1);
        fetch(32'h0, 1'b1);
        fetch(32'h4, 1'b1);
        fetch(32'h8, 1'b1);
        idle(1'b1);

        fetch(32'h20, 1'b0);
        repeat (3) fetch(32'h24, 1'b0);
        idle(1'b1);

        cyc(1'b1, 32'h10, 1'b1, 1'b1, 32'h10, 8'hAA);
        fetch(32'h10, 1'b1);
        idle(1'b1);

        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            if (k <= 5)      a = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
            else if (k == 6) a = 32'hF00 + {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            else if (k == 7) a = {20'd0, 10'($urandom), 2'b00} | 32'($urandom_range(1, 3));
            else if (k == 8) a = 32'h1000 + 32'($urandom_range(0, 65535));
            else             a = 32'hFFC;
            pa = 32'h40 + 32'($urandom_range(0, 191));
            if ($urandom_range(0, 4) == 0) pa = pa + 32'h1000;
            cyc(1'($urandom_range(0, 1)), a, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) == 0), pa, 8'($urandom));
        end
        idle(1'b1);

        fetch(32'h0, 1'b0);
        idle(1'b0);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_resp_valid", resp_valid, 1'b0);
        chk("async_rst_instruction", instruction, '0);
        chk("async_rst_resp_err", resp_err, 1'b0);
        cyc(1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 8'hFF);
        cyc(1'b1, 32'h0, 1'b1, 1'b1, 32'h1, 8'hFF);
        rst = 1'b1;
        idle(1'b1);
        idle(1'b1);
        fetch(32'h0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending responses, required 0", expq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
